res_st_dispatch: RTL and testbench
==================================

// Module: res_st_dispatch
// PURPOSE
//  Dispatch stage directly upstream of back_end. Takes one renamed uop per cycle.
//  Allocates the ROB tail entry and a free reservation-station slot in the uop's FU class.
//  Sources operands from phy RF, busy table, a local producer-tag table and the CDB.
//  Writes a complete res_st_cell_t into back_end one cycle after acceptance.
// PARAMETERS
//  NUM_FU      4   reservation stations (one per FU class), one-hot write select
//  RS_DEPTH    4   entries per station; RS_ADDR_W = $clog2(RS_DEPTH)
//  PHY_REGS    64  physical registers; PHY_W = $clog2(PHY_REGS)
//  ROB_DEPTH   4   ROB entries; ROB_ADDR_W = $clog2(ROB_DEPTH), Q_W = ROB_ADDR_W+1
// PORTS
//  clk                  in   1          clock, rising edge
//  rst                  in   1          async reset, active-high
//  uop_valid/uop_ready  in/out 1        accept handshake; xfer = valid & ready
//  uop_op               in   OP_W       operation code
//  uop_fu               in   2          target station index
//  uop_src1/uop_src2    in   PHY_W      physical source regs
//  uop_dest             in   PHY_W      physical destination reg
//  uop_imm/uop_use_imm  in   32/1       immediate -> cell.a; use_imm forces vk=imm, qk=0
//  phy_rf_rd{1,2}_addr  out  PHY_W      = uop_src{1,2} (combinational)
//  phy_rf_rd{1,2}_data  in   32         same-cycle read data
//  busy_rd{1,2}_addr    out  PHY_W      = uop_src{1,2}
//  busy_rd{1,2}_data    in   1          1 = value not yet produced
//  busy_table_wr_en/addr/data out 1/PHY_W/1  marks uop_dest busy on xfer (data=1)
//  rob_tail_ptr         in   ROB_ADDR_W tag given to the uop
//  rob_full             in   1          blocks acceptance
//  rob_incr_tail_ptr    out  1          = xfer (combinational)
//  rs_free_en           in   NUM_FU     station entry issued/freed this cycle
//  rs_free_addr         in   NUM_FU*RS_ADDR_W  freed entry per station
//  cdb_valid/cdb_rob_addr/cdb_value in 1/ROB_ADDR_W/32  result broadcast
//  res_st_wr_en         out  NUM_FU     one-hot station write, registered
//  res_st_wr_addr       out  RS_ADDR_W  entry written, registered
//  res_st_wr_cell       out  res_st_cell_t  cell written, registered
//  mispredicted_branch  in   1          flush
// BEHAVIOUR
//  - Reset: all free bitmaps all-ones, D2 invalid, res_st_wr_en=0, addr/cell=0, tag table=0.
//  - uop_ready = !rob_full & |free[uop_fu] & !mispredicted_branch; may depend on payload, never on valid.
//  - Cycle N (xfer):
//    - allocate lowest free index of free[uop_fu] and clear it at edge;
//    - tag_tbl[uop_dest] <= rob_tail_ptr;
//    - busy_table write and rob_incr_tail_ptr asserted in N.
//  - Operand j (k analogous):
//    - busy=0 -> v=rf data, q=0;
//    - busy=1 & cdb_valid & cdb_rob_addr==tag_tbl[src] -> v=cdb_value, q=0;
//    - else q = tag_tbl[src]+1 (Q_W bits; q==0 means ready).
//  - Cycle N+1: D2 register drives res_st_wr_*; cell.busy=1, rob_addr=tail@N, dest=uop_dest.
//    - If cdb_valid & cdb_rob_addr+1==q in N+1, D2 substitutes cdb_value and q=0 at the output.
//  - Latency: accept -> station write exactly 1 cycle; throughput 1 uop/cycle.
//  - Back-to-back dependency: uop B in N+1 reading A's dest sees busy=1 and tag=A's ROB tag.
//  - rs_free_en[i]: set free[i][rs_free_addr[i]] at edge; the slot is usable from the next cycle, not the same one.
//    - Freeing an already-free slot is illegal (assertion).
//  - Station full (free[fu]==0): ready=0, uop held by sender; no ROB or busy side effect.
//  - ROB tail wraps modulo ROB_DEPTH; tag+1 never overflows Q_W.
//  - mispredicted_branch: the D2 write is suppressed that cycle, all free bitmaps are set to ones, and no xfer occurs.
//    - Tag table is untouched.
//  - Reset mid-operation: pending D2 write is dropped; no partial cell reaches back_end.
// STRUCTURE
//  - qu_pkg: res_st_cell_t, res_st_addr_t, rob_addr_t, phy_rf_addr_t, phy_rf_data_t, q_tag_t.
//  - qu_pkg: NUM_FU, RS_DEPTH, ROB_DEPTH.
//  - Sub-module rs_free_list: per-station bitmap with lowest-index priority encoder, instantiated NUM_FU times.
//  - Tag table, operand select and D2 register stay in this module.
// TESTING
//  - Ready ops: src busy=0, rf=11/12, fu=0, tail=2 -> N+1 wr_en=0001, addr=0, vj=11, vk=12, qj=qk=0, rob_addr=2.
//  - Chain: A dest=5 tail=0 at N, B src1=5 at N+1 -> B qj=1.
//    - CDB rob0 value 99 in N+2 -> B cell vj=99, qj=0.
//  - Same-cycle CDB: src busy, tag=3, CDB rob3 value 7 in xfer cycle -> vj=7, qj=0.
//  - Station full: 4 uops fu=2, 5th held (ready=0).
//    - rs_free_en[2] addr 1 at M -> 5th accepted at M+1 into entry 1.
//  - rob_full=1 -> ready=0, rob_incr_tail_ptr=0, busy_table_wr_en=0 for 3 cycles.
//  - mispredicted_branch in D2 cycle -> wr_en=0000; next uop gets entry 0 in every station.
//    - rst mid-stream -> all outputs 0.

Source files
------------

// File: rtl/qu_pkg.sv
// Shared types, sizes and helpers for the dispatch stage and its reservation-station bookkeeping.
package qu_pkg;

  localparam int NUM_FU     = 4;
  localparam int RS_DEPTH   = 4;
  localparam int PHY_REGS   = 64;
  localparam int ROB_DEPTH  = 4;
  localparam int OP_W       = 6;
  localparam int RS_ADDR_W  = $clog2(RS_DEPTH);
  localparam int PHY_W      = $clog2(PHY_REGS);
  localparam int ROB_ADDR_W = $clog2(ROB_DEPTH);
  localparam int Q_W        = ROB_ADDR_W + 1;

  typedef logic [RS_ADDR_W-1:0]  res_st_addr_t;
  typedef logic [ROB_ADDR_W-1:0] rob_addr_t;
  typedef logic [PHY_W-1:0]      phy_rf_addr_t;
  typedef logic [31:0]           phy_rf_data_t;
  typedef logic [Q_W-1:0]        q_tag_t;
  typedef logic [OP_W-1:0]       op_t;

  typedef struct packed {
    logic         busy;
    op_t          op;
    phy_rf_addr_t dest;
    phy_rf_data_t vj;
    phy_rf_data_t vk;
    q_tag_t       qj;
    q_tag_t       qk;
    phy_rf_data_t a;
    rob_addr_t    rob_addr;
  } res_st_cell_t;

  typedef struct packed {
    phy_rf_data_t v;
    q_tag_t       q;
  } operand_t;

  // A waiting operand carries its producer's ROB tag plus one so that zero can mean "ready".
  function automatic q_tag_t tag_to_q(input rob_addr_t tag);
    return q_tag_t'({1'b0, tag}) + q_tag_t'(1);
  endfunction

  // Pick an operand from the register file, a same-cycle CDB broadcast, or leave it waiting on its producer.
  function automatic operand_t select_operand(input logic busy, input phy_rf_data_t rf_data,
                                              input rob_addr_t tag, input logic cdb_valid,
                                              input rob_addr_t cdb_addr, input phy_rf_data_t cdb_value);
    operand_t op;
    op.v = rf_data;
    op.q = '0;
    if (busy) begin
      if (cdb_valid && (cdb_addr == tag)) begin
        op.v = cdb_value;
      end else begin
        op.v = '0;
        op.q = tag_to_q(tag);
      end
    end
    return op;
  endfunction

endpackage

// File: rtl/rs_free_list.sv
// Free-entry bitmap for one reservation station; hands out the lowest free entry.
module rs_free_list
  import qu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 alloc_en,
  input  logic                 free_en,
  input  logic [RS_ADDR_W-1:0] free_addr,
  output logic                 has_free,
  output logic [RS_ADDR_W-1:0] alloc_addr
);

  logic [RS_DEPTH-1:0] free_bits;

  assign has_free = |free_bits;

  // Priority encoder: scanning downward leaves the lowest set index in alloc_addr.
  always_comb begin
    alloc_addr = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (free_bits[i]) alloc_addr = RS_ADDR_W'(i);
    end
  end

  // A freed entry only becomes allocatable after the edge; a flush frees everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      free_bits <= '1;
    end else if (flush) begin
      free_bits <= '1;
    end else begin
      if (alloc_en) free_bits[alloc_addr] <= 1'b0;
      if (free_en)  free_bits[free_addr]  <= 1'b1;
    end
  end

  // Releasing an entry that is already free means the back end lost track of its occupancy.
  a_no_double_free: assert property (@(posedge clk) disable iff (rst)
                                     (free_en && !flush) |-> !free_bits[free_addr]);

endmodule

// File: rtl/res_st_dispatch.sv
// Dispatch stage: allocates ROB tag and station entry, gathers operands, writes the cell one cycle later.
module res_st_dispatch
  import qu_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          uop_valid,
  output logic                          uop_ready,
  input  logic [OP_W-1:0]               uop_op,
  input  logic [1:0]                    uop_fu,
  input  logic [PHY_W-1:0]              uop_src1,
  input  logic [PHY_W-1:0]              uop_src2,
  input  logic [PHY_W-1:0]              uop_dest,
  input  logic [31:0]                   uop_imm,
  input  logic                          uop_use_imm,
  output logic [PHY_W-1:0]              phy_rf_rd1_addr,
  input  logic [31:0]                   phy_rf_rd1_data,
  output logic [PHY_W-1:0]              phy_rf_rd2_addr,
  input  logic [31:0]                   phy_rf_rd2_data,
  output logic [PHY_W-1:0]              busy_rd1_addr,
  input  logic                          busy_rd1_data,
  output logic [PHY_W-1:0]              busy_rd2_addr,
  input  logic                          busy_rd2_data,
  output logic                          busy_table_wr_en,
  output logic [PHY_W-1:0]              busy_table_wr_addr,
  output logic                          busy_table_wr_data,
  input  logic [ROB_ADDR_W-1:0]         rob_tail_ptr,
  input  logic                          rob_full,
  output logic                          rob_incr_tail_ptr,
  input  logic [NUM_FU-1:0]             rs_free_en,
  input  logic [NUM_FU*RS_ADDR_W-1:0]   rs_free_addr,
  input  logic                          cdb_valid,
  input  logic [ROB_ADDR_W-1:0]         cdb_rob_addr,
  input  logic [31:0]                   cdb_value,
  output logic [NUM_FU-1:0]             res_st_wr_en,
  output logic [RS_ADDR_W-1:0]          res_st_wr_addr,
  output res_st_cell_t                  res_st_wr_cell,
  input  logic                          mispredicted_branch
);

  logic                  xfer;
  logic [NUM_FU-1:0]     fu_has_free;
  logic [NUM_FU-1:0]     fu_alloc;
  logic [RS_ADDR_W-1:0]  fu_alloc_addr [NUM_FU];
  rob_addr_t             tag_tbl [PHY_REGS];
  operand_t              op_j;
  operand_t              op_k;
  res_st_cell_t          new_cell;
  logic                  d2_valid;
  logic [NUM_FU-1:0]     d2_fu;
  res_st_addr_t          d2_addr;
  res_st_cell_t          d2_cell;

  assign uop_ready          = !rob_full && fu_has_free[uop_fu] && !mispredicted_branch;
  assign xfer               = uop_valid && uop_ready;
  assign rob_incr_tail_ptr  = xfer;
  assign busy_table_wr_en   = xfer;
  assign busy_table_wr_addr = uop_dest;
  assign busy_table_wr_data = 1'b1;
  assign phy_rf_rd1_addr    = uop_src1;
  assign phy_rf_rd2_addr    = uop_src2;
  assign busy_rd1_addr      = uop_src1;
  assign busy_rd2_addr      = uop_src2;

  // Only the station named by the accepted uop consumes an entry.
  always_comb begin
    fu_alloc = '0;
    if (xfer) fu_alloc[uop_fu] = 1'b1;
  end

  for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
    rs_free_list u_free_list (
      .clk        (clk),
      .rst        (rst),
      .flush      (mispredicted_branch),
      .alloc_en   (fu_alloc[i]),
      .free_en    (rs_free_en[i]),
      .free_addr  (rs_free_addr[i*RS_ADDR_W +: RS_ADDR_W]),
      .has_free   (fu_has_free[i]),
      .alloc_addr (fu_alloc_addr[i])
    );
  end

  // Remember which ROB entry will produce each physical register; a flush leaves it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PHY_REGS; i++) tag_tbl[i] <= '0;
    end else if (xfer) begin
      tag_tbl[uop_dest] <= rob_tail_ptr;
    end
  end

  // Assemble the cell for the uop being accepted; an immediate replaces the second operand outright.
  always_comb begin
    op_j = select_operand(busy_rd1_data, phy_rf_rd1_data, tag_tbl[uop_src1],
                          cdb_valid, cdb_rob_addr, cdb_value);
    op_k = select_operand(busy_rd2_data, phy_rf_rd2_data, tag_tbl[uop_src2],
                          cdb_valid, cdb_rob_addr, cdb_value);
    if (uop_use_imm) begin
      op_k.v = uop_imm;
      op_k.q = '0;
    end
    new_cell          = '0;
    new_cell.busy     = 1'b1;
    new_cell.op       = uop_op;
    new_cell.dest     = uop_dest;
    new_cell.vj       = op_j.v;
    new_cell.qj       = op_j.q;
    new_cell.vk       = op_k.v;
    new_cell.qk       = op_k.q;
    new_cell.a        = uop_imm;
    new_cell.rob_addr = rob_tail_ptr;
  end

  // D2 stage register: holds the accepted uop for exactly one cycle before the station write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d2_valid <= 1'b0;
      d2_fu    <= '0;
      d2_addr  <= '0;
      d2_cell  <= '0;
    end else begin
      d2_valid <= xfer;
      if (xfer) begin
        d2_fu   <= fu_alloc;
        d2_addr <= fu_alloc_addr[uop_fu];
        d2_cell <= new_cell;
      end
    end
  end

  // Catch a result broadcast that lands while the cell sits in D2, so the station never misses it.
  always_comb begin
    res_st_wr_cell = d2_cell;
    if (cdb_valid && (tag_to_q(cdb_rob_addr) == d2_cell.qj)) begin
      res_st_wr_cell.vj = cdb_value;
      res_st_wr_cell.qj = '0;
    end
    if (cdb_valid && (tag_to_q(cdb_rob_addr) == d2_cell.qk)) begin
      res_st_wr_cell.vk = cdb_value;
      res_st_wr_cell.qk = '0;
    end
  end

  assign res_st_wr_en   = (d2_valid && !mispredicted_branch) ? d2_fu : '0;
  assign res_st_wr_addr = d2_addr;

endmodule

// File: tb/tb_res_st_dispatch.sv
// Self-checking bench for res_st_dispatch: directed scenarios then random traffic against a reference model.
module tb_res_st_dispatch;
  import qu_pkg::*;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        uop_valid, uop_ready;
  logic [OP_W-1:0]             uop_op;
  logic [1:0]                  uop_fu;
  logic [PHY_W-1:0]            uop_src1, uop_src2, uop_dest;
  logic [31:0]                 uop_imm;
  logic                        uop_use_imm;
  logic [PHY_W-1:0]            phy_rf_rd1_addr, phy_rf_rd2_addr;
  logic [31:0]                 phy_rf_rd1_data, phy_rf_rd2_data;
  logic [PHY_W-1:0]            busy_rd1_addr, busy_rd2_addr;
  logic                        busy_rd1_data, busy_rd2_data;
  logic                        busy_table_wr_en, busy_table_wr_data;
  logic [PHY_W-1:0]            busy_table_wr_addr;
  logic [ROB_ADDR_W-1:0]       rob_tail_ptr;
  logic                        rob_full, rob_incr_tail_ptr;
  logic [NUM_FU-1:0]           rs_free_en;
  logic [NUM_FU*RS_ADDR_W-1:0] rs_free_addr;
  logic                        cdb_valid;
  logic [ROB_ADDR_W-1:0]       cdb_rob_addr;
  logic [31:0]                 cdb_value;
  logic [NUM_FU-1:0]           res_st_wr_en;
  logic [RS_ADDR_W-1:0]        res_st_wr_addr;
  res_st_cell_t                res_st_wr_cell;
  logic                        mispredicted_branch;

  int checks = 0;
  int errors = 0;

  // Reference model: which entries are occupied, who produces each register, what sits in D2.
  bit          m_free [NUM_FU][RS_DEPTH];
  int          m_tag  [PHY_REGS];
  bit          p_valid;
  int          p_fu, p_addr, p_dest, p_rob, p_wj, p_wk;
  logic [31:0] p_vj, p_vk, p_a;
  logic [OP_W-1:0] p_op;
  bit          last_xfer;
  int          rob_tail_cnt;

  res_st_dispatch dut (
    .clk(clk), .rst(rst), .uop_valid(uop_valid), .uop_ready(uop_ready), .uop_op(uop_op),
    .uop_fu(uop_fu), .uop_src1(uop_src1), .uop_src2(uop_src2), .uop_dest(uop_dest),
    .uop_imm(uop_imm), .uop_use_imm(uop_use_imm),
    .phy_rf_rd1_addr(phy_rf_rd1_addr), .phy_rf_rd1_data(phy_rf_rd1_data),
    .phy_rf_rd2_addr(phy_rf_rd2_addr), .phy_rf_rd2_data(phy_rf_rd2_data),
    .busy_rd1_addr(busy_rd1_addr), .busy_rd1_data(busy_rd1_data),
    .busy_rd2_addr(busy_rd2_addr), .busy_rd2_data(busy_rd2_data),
    .busy_table_wr_en(busy_table_wr_en), .busy_table_wr_addr(busy_table_wr_addr),
    .busy_table_wr_data(busy_table_wr_data), .rob_tail_ptr(rob_tail_ptr), .rob_full(rob_full),
    .rob_incr_tail_ptr(rob_incr_tail_ptr), .rs_free_en(rs_free_en), .rs_free_addr(rs_free_addr),
    .cdb_valid(cdb_valid), .cdb_rob_addr(cdb_rob_addr), .cdb_value(cdb_value),
    .res_st_wr_en(res_st_wr_en), .res_st_wr_addr(res_st_wr_addr), .res_st_wr_cell(res_st_wr_cell),
    .mispredicted_branch(mispredicted_branch)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_FU; i++)
      for (int j = 0; j < RS_DEPTH; j++) m_free[i][j] = 1'b1;
    for (int r = 0; r < PHY_REGS; r++) m_tag[r] = 0;
    p_valid   = 1'b0;
    last_xfer = 1'b0;
  endtask

  function automatic bit model_ready();
    bit any_free = 1'b0;
    for (int j = 0; j < RS_DEPTH; j++) if (m_free[uop_fu][j]) any_free = 1'b1;
    return !rob_full && any_free && !mispredicted_branch;
  endfunction

  // Cell as back_end should see it now, including a broadcast arriving this very cycle.
  function automatic res_st_cell_t exp_cell();
    res_st_cell_t c = '0;
    c.busy     = 1'b1;
    c.op       = p_op;
    c.dest     = PHY_W'(p_dest);
    c.rob_addr = ROB_ADDR_W'(p_rob);
    c.a        = p_a;
    if (p_wj < 0) c.vj = p_vj;
    else if (cdb_valid && int'(cdb_rob_addr) == p_wj) c.vj = cdb_value;
    else c.qj = Q_W'(p_wj + 1);
    if (p_wk < 0) c.vk = p_vk;
    else if (cdb_valid && int'(cdb_rob_addr) == p_wk) c.vk = cdb_value;
    else c.qk = Q_W'(p_wk + 1);
    return c;
  endfunction

  task automatic check_output();
    bit exp_ready, exp_xfer;
    logic [NUM_FU-1:0] exp_en;
    exp_ready = model_ready();
    exp_xfer  = uop_valid && exp_ready;
    check("uop_ready", 128'(uop_ready), 128'(exp_ready));
    check("rob_incr_tail_ptr", 128'(rob_incr_tail_ptr), 128'(exp_xfer));
    check("busy_table_wr_en", 128'(busy_table_wr_en), 128'(exp_xfer));
    check("phy_rf_rd2_addr", 128'(phy_rf_rd2_addr), 128'(uop_src2));
    check("busy_rd1_addr", 128'(busy_rd1_addr), 128'(uop_src1));
    if (exp_xfer) begin
      check("busy_table_wr_addr", 128'(busy_table_wr_addr), 128'(uop_dest));
      check("busy_table_wr_data", 128'(busy_table_wr_data), 128'(1'b1));
    end
    exp_en = '0;
    if (p_valid && !mispredicted_branch) exp_en[p_fu] = 1'b1;
    check("res_st_wr_en", 128'(res_st_wr_en), 128'(exp_en));
    if (exp_en != '0) begin
      check("res_st_wr_addr", 128'(res_st_wr_addr), 128'(p_addr));
      check("res_st_wr_cell", 128'(res_st_wr_cell), 128'(exp_cell()));
    end
  endtask

  // Advance the model across one clock edge using the inputs that were applied before it.
  task automatic model_update();
    bit xfer;
    int a;
    xfer      = uop_valid && model_ready();
    last_xfer = xfer;
    if (mispredicted_branch) begin
      for (int i = 0; i < NUM_FU; i++)
        for (int j = 0; j < RS_DEPTH; j++) m_free[i][j] = 1'b1;
      p_valid = 1'b0;
      return;
    end
    p_valid = xfer;
    if (xfer) begin
      a = -1;
      for (int j = RS_DEPTH - 1; j >= 0; j--) if (m_free[uop_fu][j]) a = j;
      m_free[uop_fu][a] = 1'b0;
      p_fu = int'(uop_fu); p_addr = a; p_op = uop_op; p_dest = int'(uop_dest);
      p_rob = int'(rob_tail_ptr); p_a = uop_imm;
      if (!busy_rd1_data) begin p_wj = -1; p_vj = phy_rf_rd1_data; end
      else if (cdb_valid && int'(cdb_rob_addr) == m_tag[uop_src1]) begin p_wj = -1; p_vj = cdb_value; end
      else begin p_wj = m_tag[uop_src1]; p_vj = '0; end
      if (uop_use_imm) begin p_wk = -1; p_vk = uop_imm; end
      else if (!busy_rd2_data) begin p_wk = -1; p_vk = phy_rf_rd2_data; end
      else if (cdb_valid && int'(cdb_rob_addr) == m_tag[uop_src2]) begin p_wk = -1; p_vk = cdb_value; end
      else begin p_wk = m_tag[uop_src2]; p_vk = '0; end
      m_tag[uop_dest] = int'(rob_tail_ptr);
    end
    for (int i = 0; i < NUM_FU; i++)
      if (rs_free_en[i]) m_free[i][rs_free_addr[i*RS_ADDR_W +: RS_ADDR_W]] = 1'b1;
  endtask

  task automatic tick();
    @(negedge clk);
    check_output();
    @(posedge clk);
    model_update();
    #1;
    if (last_xfer) rob_tail_cnt = (rob_tail_cnt + 1) % ROB_DEPTH;
  endtask

  task automatic set_idle();
    uop_valid = 1'b0; uop_op = '0; uop_fu = '0; uop_src1 = '0; uop_src2 = '0; uop_dest = '0;
    uop_imm = '0; uop_use_imm = 1'b0; phy_rf_rd1_data = '0; phy_rf_rd2_data = '0;
    busy_rd1_data = 1'b0; busy_rd2_data = 1'b0; rob_full = 1'b0; rob_tail_ptr = '0;
    rs_free_en = '0; rs_free_addr = '0; cdb_valid = 1'b0; cdb_rob_addr = '0; cdb_value = '0;
    mispredicted_branch = 1'b0;
  endtask

  task automatic apply_stimulus();
    int occ[$];
    uop_valid           = ($urandom_range(0, 9) < 8);
    uop_op              = OP_W'($urandom);
    uop_fu              = 2'($urandom_range(0, NUM_FU - 1));
    uop_src1            = PHY_W'($urandom_range(0, PHY_REGS - 1));
    uop_src2            = PHY_W'($urandom_range(0, PHY_REGS - 1));
    uop_dest            = PHY_W'($urandom_range(0, PHY_REGS - 1));
    uop_imm             = $urandom;
    uop_use_imm         = ($urandom_range(0, 3) == 0);
    phy_rf_rd1_data     = $urandom;
    phy_rf_rd2_data     = $urandom;
    busy_rd1_data       = 1'($urandom_range(0, 1));
    busy_rd2_data       = 1'($urandom_range(0, 1));
    rob_tail_ptr        = ROB_ADDR_W'(rob_tail_cnt);
    rob_full            = ($urandom_range(0, 9) == 0);
    mispredicted_branch = ($urandom_range(0, 24) == 0);
    cdb_valid           = 1'($urandom_range(0, 1));
    cdb_rob_addr        = ROB_ADDR_W'($urandom_range(0, ROB_DEPTH - 1));
    cdb_value           = $urandom;
    rs_free_en          = '0;
    rs_free_addr        = '0;
    if (!mispredicted_branch) begin
      for (int i = 0; i < NUM_FU; i++) begin
        occ.delete();
        for (int j = 0; j < RS_DEPTH; j++) if (!m_free[i][j]) occ.push_back(j);
        if (occ.size() > 0 && $urandom_range(0, 3) == 0) begin
          rs_free_en[i] = 1'b1;
          rs_free_addr[i*RS_ADDR_W +: RS_ADDR_W] = RS_ADDR_W'(occ[$urandom_range(0, occ.size() - 1)]);
        end
      end
    end
  endtask

  initial begin
    set_idle();
    rst = 1'b1;
    model_reset();
    rob_tail_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_wr_en", 128'(res_st_wr_en), 128'(0));
    check("reset_wr_addr", 128'(res_st_wr_addr), 128'(0));
    check("reset_wr_cell", 128'(res_st_wr_cell), 128'(0));
    rst = 1'b0;

    $display("[TB] ready operands");
    uop_valid = 1'b1; uop_fu = 2'd0; uop_src1 = 6'd1; uop_src2 = 6'd2; uop_dest = 6'd10;
    uop_op = 6'd3; phy_rf_rd1_data = 32'd11; phy_rf_rd2_data = 32'd12; rob_tail_ptr = 2'd2;
    tick();
    set_idle();
    #1;
    check("ready_wr_en", 128'(res_st_wr_en), 128'(4'b0001));
    check("ready_wr_addr", 128'(res_st_wr_addr), 128'(0));
    check("ready_vj", 128'(res_st_wr_cell.vj), 128'(32'd11));
    check("ready_vk", 128'(res_st_wr_cell.vk), 128'(32'd12));
    check("ready_qj_qk", 128'({res_st_wr_cell.qj, res_st_wr_cell.qk}), 128'(0));
    check("ready_rob_addr", 128'(res_st_wr_cell.rob_addr), 128'(2'd2));
    tick();

    $display("[TB] dependency chain");
    uop_valid = 1'b1; uop_fu = 2'd1; uop_dest = 6'd5; rob_tail_ptr = 2'd0;
    tick();
    set_idle();
    uop_valid = 1'b1; uop_fu = 2'd1; uop_src1 = 6'd5; busy_rd1_data = 1'b1; uop_dest = 6'd6;
    rob_tail_ptr = 2'd1; phy_rf_rd1_data = 32'hdead_beef;
    tick();
    set_idle();
    #1;
    check("chain_qj", 128'(res_st_wr_cell.qj), 128'(3'd1));
    cdb_valid = 1'b1; cdb_rob_addr = 2'd0; cdb_value = 32'd99;
    #1;
    check("chain_cdb_vj", 128'(res_st_wr_cell.vj), 128'(32'd99));
    check("chain_cdb_qj", 128'(res_st_wr_cell.qj), 128'(0));
    tick();

    $display("[TB] same-cycle broadcast");
    set_idle();
    uop_valid = 1'b1; uop_fu = 2'd3; uop_dest = 6'd20; rob_tail_ptr = 2'd3;
    tick();
    set_idle();
    uop_valid = 1'b1; uop_fu = 2'd3; uop_src1 = 6'd20; busy_rd1_data = 1'b1; uop_dest = 6'd21;
    cdb_valid = 1'b1; cdb_rob_addr = 2'd3; cdb_value = 32'd7;
    tick();
    set_idle();
    #1;
    check("samecyc_vj", 128'(res_st_wr_cell.vj), 128'(32'd7));
    check("samecyc_qj", 128'(res_st_wr_cell.qj), 128'(0));
    tick();

    $display("[TB] station full");
    for (int i = 0; i < RS_DEPTH; i++) begin
      set_idle();
      uop_valid = 1'b1; uop_fu = 2'd2; uop_dest = PHY_W'(30 + i); rob_tail_ptr = ROB_ADDR_W'(i);
      tick();
    end
    set_idle();
    uop_valid = 1'b1; uop_fu = 2'd2; uop_dest = 6'd40;
    #1;
    check("full_ready", 128'(uop_ready), 128'(0));
    tick();
    rs_free_en = 4'b0100;
    rs_free_addr[2*RS_ADDR_W +: RS_ADDR_W] = 2'd1;
    #1;
    check("free_same_cycle_ready", 128'(uop_ready), 128'(0));
    tick();
    rs_free_en = '0;
    rs_free_addr = '0;
    #1;
    check("free_next_cycle_ready", 128'(uop_ready), 128'(1));
    tick();
    set_idle();
    #1;
    check("refill_wr_en", 128'(res_st_wr_en), 128'(4'b0100));
    check("refill_wr_addr", 128'(res_st_wr_addr), 128'(1));
    tick();

    $display("[TB] rob full");
    uop_valid = 1'b1; uop_fu = 2'd0; uop_dest = 6'd41; rob_full = 1'b1;
    for (int n = 0; n < 3; n++) begin
      #1;
      check("robfull_ready", 128'(uop_ready), 128'(0));
      check("robfull_incr", 128'(rob_incr_tail_ptr), 128'(0));
      check("robfull_busy_wr", 128'(busy_table_wr_en), 128'(0));
      tick();
    end

    $display("[TB] mispredict");
    set_idle();
    uop_valid = 1'b1; uop_fu = 2'd0; uop_dest = 6'd42; rob_tail_ptr = 2'd1;
    tick();
    set_idle();
    mispredicted_branch = 1'b1;
    #1;
    check("flush_wr_en", 128'(res_st_wr_en), 128'(0));
    tick();
    for (int f = 0; f < NUM_FU; f++) begin
      set_idle();
      uop_valid = 1'b1; uop_fu = 2'(f); uop_dest = PHY_W'(50 + f); rob_tail_ptr = ROB_ADDR_W'(f);
      tick();
      set_idle();
      #1;
      check("post_flush_addr", 128'(res_st_wr_addr), 128'(0));
      tick();
    end

    $display("[TB] random traffic");
    rob_tail_cnt = 0;
    for (int n = 0; n < 400; n++) begin
      apply_stimulus();
      tick();
    end

    $display("[TB] reset mid-stream");
    set_idle();
    uop_valid = 1'b1; uop_fu = 2'd1; uop_dest = 6'd60; rob_tail_ptr = 2'd1;
    phy_rf_rd1_data = 32'h1234;
    tick();
    set_idle();
    rst = 1'b1;
    #1;
    check("midrst_wr_en", 128'(res_st_wr_en), 128'(0));
    check("midrst_wr_addr", 128'(res_st_wr_addr), 128'(0));
    check("midrst_wr_cell", 128'(res_st_wr_cell), 128'(0));
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    rob_tail_cnt = 0;
    for (int n = 0; n < 40; n++) begin
      apply_stimulus();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
